// File: rtl/cgra_scalar_sequencer_if.sv
// Bus bundle between the scalar sequencer and its environment: program
// load port, run handshake, scalar PE drive/return and register readout.
interface cgra_scalar_sequencer_if #(
  parameter int DW  = 32,
  parameter int PCW = 4
);
  logic            prog_we;
  logic [PCW-1:0]  prog_addr;
  logic [DW+11:0]  prog_data;
  logic            start;
  logic            busy;
  logic            done;
  logic            timeout;
  logic [DW-1:0]   pe_inp1;
  logic [DW-1:0]   pe_inp2;
  logic [DW-1:0]   pe_imm;
  logic [2:0]      pe_op;
  logic [DW-1:0]   pe_out1;
  logic            pe_flag_eq;
  logic [2:0]      dbg_addr;
  logic [DW-1:0]   dbg_data;

  // Sequencer side.
  modport master (
    input  prog_we, prog_addr, prog_data, start, pe_out1, pe_flag_eq, dbg_addr,
    output busy, done, timeout, pe_inp1, pe_inp2, pe_imm, pe_op, dbg_data
  );

  // Environment side: host, scalar PE and debug reader.
  modport slave (
    output prog_we, prog_addr, prog_data, start, pe_out1, pe_flag_eq, dbg_addr,
    input  busy, done, timeout, pe_inp1, pe_inp2, pe_imm, pe_op, dbg_data
  );
endinterface

// File: rtl/cgra_scalar_sequencer.sv
// Scalar-path control sequencer: program memory, 8-entry register file
// (r0 hardwired to zero), IDLE/FETCH/EXEC FSM driving the scalar PE, and a
// step-limit watchdog that bounds every run.
module cgra_scalar_sequencer #(
  parameter int dwidth_int = 32,
  parameter int IMEM_DEPTH = 16,
  parameter int MAX_STEPS  = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  cgra_scalar_sequencer_if.master  bus
);
  localparam int PCW = $clog2(IMEM_DEPTH);
  localparam int IW  = dwidth_int + 12;
  localparam int SCW = $clog2(MAX_STEPS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;

  localparam logic [2:0] OP_LUI  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_BEQ  = 3'b010;
  localparam logic [2:0] OP_HALT = 3'b111;

  logic [1:0]            state_q, state_d;
  logic [PCW-1:0]        pc_q, pc_d;
  logic [IW-1:0]         ir_q, ir_d;
  logic [SCW-1:0]        steps_q, steps_d;
  logic                  done_q, done_d;
  logic                  timeout_q, timeout_d;
  logic [IW-1:0]         imem_q [IMEM_DEPTH];
  logic [dwidth_int-1:0] regs_q [8];
  logic                  rf_we;
  logic [2:0]            rf_waddr;
  logic [dwidth_int-1:0] rf_wdata;

  logic [2:0]            ir_op, ir_rd, ir_rs1, ir_rs2;
  logic [dwidth_int-1:0] ir_imm;

  assign ir_op  = ir_q[IW-1 -: 3];
  assign ir_rd  = ir_q[dwidth_int+8 -: 3];
  assign ir_rs1 = ir_q[dwidth_int+5 -: 3];
  assign ir_rs2 = ir_q[dwidth_int+2 -: 3];
  assign ir_imm = ir_q[dwidth_int-1:0];

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
  assign bus.timeout  = timeout_q;
  assign bus.dbg_data = regs_q[bus.dbg_addr];

  // Next-state logic: run handshake, fetch, execute/commit and watchdog.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    steps_d   = steps_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    rf_we     = 1'b0;
    rf_waddr  = ir_rd;
    rf_wdata  = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_FETCH;
          pc_d      = '0;
          steps_d   = '0;
          timeout_d = 1'b0;
        end
      end
      S_FETCH: begin
        ir_d    = imem_q[pc_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (ir_op == OP_HALT) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          if (ir_op == OP_LUI) begin
            rf_we    = (ir_rd != 3'd0);
            rf_wdata = ir_imm;
          end else if (ir_op == OP_ADDI) begin
            rf_we    = (ir_rd != 3'd0);
            rf_wdata = bus.pe_out1;
          end
          // pc+1 wraps naturally at IMEM_DEPTH-1 in PCW bits.
          pc_d    = (ir_op == OP_BEQ && bus.pe_flag_eq) ? ir_imm[PCW-1:0]
                                                        : pc_q + PCW'(1);
          steps_d = steps_q + SCW'(1);
          if (steps_d == SCW'(MAX_STEPS)) begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            timeout_d = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // PE drive: live operands only in EXEC, otherwise a neutral halt opcode.
  always_comb begin
    bus.pe_op   = OP_HALT;
    bus.pe_inp1 = '0;
    bus.pe_inp2 = '0;
    bus.pe_imm  = '0;
    if (state_q == S_EXEC) begin
      bus.pe_op   = ir_op;
      bus.pe_inp1 = regs_q[ir_rs1];
      bus.pe_inp2 = regs_q[ir_rs2];
      bus.pe_imm  = ir_imm;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      steps_q   <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      steps_q   <= steps_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  // Register file write-back; r0 is never written so it always reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

  // Program memory load, accepted only while idle.
  always_ff @(posedge clk) begin
    // NOTE: program memory has no reset so it can map onto plain RAM.
    if (bus.prog_we && state_q == S_IDLE) imem_q[bus.prog_addr] <= bus.prog_data;
  end
endmodule

// File: tb/tb_cgra_scalar_sequencer.sv
// Directed bench for cgra_scalar_sequencer with a behavioural scalar PE
// (addi: inp1+imm, beq: flag_eq = inp1==inp2) and a 16-step watchdog.
module tb_cgra_scalar_sequencer;
  localparam int DW = 32;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  cgra_scalar_sequencer_if #(.DW(DW), .PCW(4)) bus ();

  cgra_scalar_sequencer #(
    .dwidth_int(DW), .IMEM_DEPTH(16), .MAX_STEPS(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scalar PE model.
  always_comb begin
    bus.pe_out1    = (bus.pe_op == 3'b001) ? bus.pe_inp1 + bus.pe_imm : '0;
    bus.pe_flag_eq = (bus.pe_op == 3'b010) && (bus.pe_inp1 == bus.pe_inp2);
  end

  function automatic logic [43:0] ins(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2,
                                      input logic [31:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  task automatic load(input int addr, input logic [43:0] word);
    @(negedge clk);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 4'(addr);
    bus.prog_data = word;
    @(posedge clk);
    #1 bus.prog_we = 1'b0;
  endtask

  task automatic rd_reg(input int addr, output logic [31:0] val);
    bus.dbg_addr = 3'(addr);
    #1 val = bus.dbg_data;
  endtask

  // Starts a run and counts edges after E0 until done is seen (bounded).
  // With abuse_at >= 0, start and a halt write to imem[2] are driven for
  // the edge following E(abuse_at).
  task automatic run_prog(input int abuse_at, output int n, output logic busy0,
                          output logic done_next);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    busy0 = bus.busy;
    n = 0;
    while (n < 200 && bus.done !== 1'b1) begin
      if (n == abuse_at) begin
        bus.start = 1'b1; bus.prog_we = 1'b1; bus.prog_addr = 4'd2;
        bus.prog_data = ins(3'b111, 0, 0, 0, 0);
      end else begin
        bus.start = 1'b0; bus.prog_we = 1'b0;
      end
      @(posedge clk);
      n++;
      #1;
    end
    bus.start = 1'b0; bus.prog_we = 1'b0;
    @(posedge clk);
    #1 done_next = bus.done;
  endtask

  task automatic load_loop();
    load(0, ins(3'b000, 1, 0, 0, 0));
    load(1, ins(3'b000, 2, 0, 0, 3));
    load(2, ins(3'b001, 1, 1, 0, 1));
    load(3, ins(3'b010, 0, 1, 2, 5));
    load(4, ins(3'b010, 0, 0, 0, 2));
    load(5, ins(3'b111, 0, 0, 0, 0));
  endtask

  task automatic test_reset();
    logic [31:0] v;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else pass_cnt++;
    total_cnt++; if (bus.timeout !== 1'b0) $display("FAIL reset_timeout got %b want 0", bus.timeout); else pass_cnt++;
    total_cnt++; if (bus.pe_op !== 3'b111) $display("FAIL reset_pe_op got %b want 111", bus.pe_op); else pass_cnt++;
    total_cnt++; if (bus.pe_inp1 !== 32'd0) $display("FAIL reset_pe_inp1 got %h want 0", bus.pe_inp1); else pass_cnt++;
    total_cnt++; if (bus.pe_inp2 !== 32'd0) $display("FAIL reset_pe_inp2 got %h want 0", bus.pe_inp2); else pass_cnt++;
    total_cnt++; if (bus.pe_imm !== 32'd0) $display("FAIL reset_pe_imm got %h want 0", bus.pe_imm); else pass_cnt++;
    for (int a = 0; a < 8; a++) begin
      rd_reg(a, v);
      total_cnt++; if (v !== 32'd0) $display("FAIL reset_dbg r%0d got %h want 0", a, v); else pass_cnt++;
    end
    @(negedge clk) rst = 1'b0;
  endtask

  // [lui r1,5; addi r2,r1,3; halt]: 2 commits, halt done after E6.
  task automatic test_straight();
    int n; logic b0, dn; logic [31:0] v;
    load(0, ins(3'b000, 1, 0, 0, 5));
    load(1, ins(3'b001, 2, 1, 0, 3));
    load(2, ins(3'b111, 0, 0, 0, 0));
    run_prog(-1, n, b0, dn);
    total_cnt++; if (b0 !== 1'b1) $display("FAIL straight_busy got %b want 1", b0); else pass_cnt++;
    total_cnt++; if (n !== 6) $display("FAIL straight_latency got E%0d want E6", n); else pass_cnt++;
    total_cnt++; if (dn !== 1'b0) $display("FAIL straight_done_pulse got %b want 0", dn); else pass_cnt++;
    total_cnt++; if (bus.timeout !== 1'b0) $display("FAIL straight_timeout got %b want 0", bus.timeout); else pass_cnt++;
    rd_reg(1, v);
    total_cnt++; if (v !== 32'd5) $display("FAIL straight_r1 got %0d want 5", v); else pass_cnt++;
    rd_reg(2, v);
    total_cnt++; if (v !== 32'd8) $display("FAIL straight_r2 got %0d want 8", v); else pass_cnt++;
  endtask

  // Loop: 2 lui + two full passes (3 each) + final addi/beq = 10 commits,
  // so the halt commits at E(2*10+2) = E22.
  task automatic test_loop();
    int n; logic b0, dn; logic [31:0] v;
    load_loop();
    run_prog(-1, n, b0, dn);
    total_cnt++; if (n !== 22) $display("FAIL loop_latency got E%0d want E22", n); else pass_cnt++;
    rd_reg(1, v);
    total_cnt++; if (v !== 32'd3) $display("FAIL loop_r1 got %0d want 3", v); else pass_cnt++;
  endtask

  task automatic test_wrap_r0();
    int n; logic b0, dn; logic [31:0] v;
    load(0, ins(3'b000, 1, 0, 0, 32'hFFFF_FFFF));
    load(1, ins(3'b001, 1, 1, 0, 1));
    load(2, ins(3'b000, 0, 0, 0, 7));
    load(3, ins(3'b111, 0, 0, 0, 0));
    run_prog(-1, n, b0, dn);
    total_cnt++; if (n !== 8) $display("FAIL r0_latency got E%0d want E8", n); else pass_cnt++;
    rd_reg(1, v);
    total_cnt++; if (v !== 32'd0) $display("FAIL arith_wrap_r1 got %h want 0", v); else pass_cnt++;
    rd_reg(0, v);
    total_cnt++; if (v !== 32'd0) $display("FAIL r0_hardwired got %h want 0", v); else pass_cnt++;
    // Setup run: r4=0, r6=2.
    load(0, ins(3'b000, 4, 0, 0, 0));
    load(1, ins(3'b000, 6, 0, 0, 2));
    load(2, ins(3'b111, 0, 0, 0, 0));
    run_prog(-1, n, b0, dn);
    // No-op fill, then: 0 addi r4+=1; 1 beq r4,r6->3; 2 beq ->13; 3 halt.
    // Path 0,1,2,13,14,15,wrap 0,1 = 8 commits, halt done after E18.
    for (int a = 0; a < 16; a++) load(a, ins(3'b011, 0, 0, 0, 0));
    load(0, ins(3'b001, 4, 4, 0, 1));
    load(1, ins(3'b010, 0, 4, 6, 3));
    load(2, ins(3'b010, 0, 0, 0, 13));
    load(3, ins(3'b111, 0, 0, 0, 0));
    run_prog(-1, n, b0, dn);
    total_cnt++; if (n !== 18) $display("FAIL pc_wrap_latency got E%0d want E18", n); else pass_cnt++;
    rd_reg(4, v);
    total_cnt++; if (v !== 32'd2) $display("FAIL pc_wrap_r4 got %0d want 2", v); else pass_cnt++;
    total_cnt++; if (bus.timeout !== 1'b0) $display("FAIL pc_wrap_timeout got %b want 0", bus.timeout); else pass_cnt++;
  endtask

  task automatic test_watchdog();
    int n; logic b0, dn;
    load(0, ins(3'b010, 0, 0, 0, 0));
    run_prog(-1, n, b0, dn);
    total_cnt++; if (n !== 32) $display("FAIL watchdog_latency got E%0d want E32", n); else pass_cnt++;
    total_cnt++; if (bus.timeout !== 1'b1) $display("FAIL watchdog_timeout got %b want 1", bus.timeout); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL watchdog_busy got %b want 0", bus.busy); else pass_cnt++;
    // Same-cycle write of halt to imem[0] and start: run sees the halt.
    @(negedge clk);
    bus.prog_we = 1'b1; bus.prog_addr = 4'd0; bus.prog_data = ins(3'b111, 0, 0, 0, 0);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.prog_we = 1'b0; bus.start = 1'b0;
    total_cnt++; if (bus.timeout !== 1'b0) $display("FAIL timeout_clear got %b want 0", bus.timeout); else pass_cnt++;
    n = 0;
    while (n < 50 && bus.done !== 1'b1) begin
      @(posedge clk); n++; #1;
    end
    total_cnt++; if (n !== 2) $display("FAIL same_cycle_write_latency got E%0d want E2", n); else pass_cnt++;
  endtask

  task automatic test_busy_abuse();
    int n; logic b0, dn; logic [31:0] v;
    load_loop();
    run_prog(3, n, b0, dn);
    total_cnt++; if (n !== 22) $display("FAIL abuse_latency got E%0d want E22", n); else pass_cnt++;
    rd_reg(1, v);
    total_cnt++; if (v !== 32'd3) $display("FAIL abuse_r1 got %0d want 3", v); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int n; logic b0, dn; logic seen_done; logic [31:0] v;
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b want 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.pe_op !== 3'b111) $display("FAIL abort_pe_op got %b want 111", bus.pe_op); else pass_cnt++;
    rd_reg(2, v);
    total_cnt++; if (v !== 32'd0) $display("FAIL abort_r2_cleared got %0d want 0", v); else pass_cnt++;
    seen_done = 1'b0;
    repeat (2) begin
      @(posedge clk); #1 if (bus.done) seen_done = 1'b1;
    end
    @(negedge clk) rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1 if (bus.done) seen_done = 1'b1;
    end
    total_cnt++; if (seen_done !== 1'b0) $display("FAIL abort_no_done got %b want 0", seen_done); else pass_cnt++;
    run_prog(-1, n, b0, dn);
    total_cnt++; if (n !== 22) $display("FAIL rerun_latency got E%0d want E22", n); else pass_cnt++;
    rd_reg(1, v);
    total_cnt++; if (v !== 32'd3) $display("FAIL rerun_r1 got %0d want 3", v); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.prog_we = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.dbg_addr = '0;
    test_reset();
    test_straight();
    test_loop();
    test_wrap_r0();
    test_watchdog();
    test_busy_abuse();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
